commit_bus_scheduler: RTL and testbench

COMMIT_BUS_SCHEDULER -- requirements
Module: commit_bus_scheduler

---
 rtl/commit_bus_scheduler.sv | 143 ++++++++++++++
 tb/tb_commit_bus_scheduler.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/commit_bus_scheduler.sv
// Seven-station round-robin commit bus arbiter with stall hold.
// Optional starvation aging: define COMMIT_BUS_SCHEDULER_AGING_EN.
module commit_bus_scheduler #(
    parameter int unsigned AGE_LIMIT = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iEnable,
    input  logic       iStall,
    input  logic [6:0] iRequest,
    output logic [6:0] oGrant,
    output logic       oGrantValid,
    output logic [2:0] oBusSelector,
    output logic [6:0] oStarved
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] grant_q, grant_d;
    logic [2:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [2:0] ptr_q, ptr_d;
    logic [6:0] starved_q, starved_d;

    logic [6:0] eligible;
    logic       arb_go;
    logic [2:0] win;
    logic       win_found;
    logic [3:0] idx;

    // The station currently on the bus is masked from this round.
    assign eligible = iRequest & ~grant_q;
    assign arb_go   = iEnable && !iStall && (eligible != 7'd0);

    always_comb begin
        win       = 3'd0;
        win_found = 1'b0;
        idx       = 4'd0;
        for (int k = 0; k < 7; k++) begin
            idx = 4'({1'b0, ptr_q}) + 4'(k);
            if (idx >= 4'd7) idx = idx - 4'd7;
            if (!win_found && eligible[idx[2:0]]) begin
                win       = idx[2:0];
                win_found = 1'b1;
            end
        end
`ifdef COMMIT_BUS_SCHEDULER_AGING_EN
        // Descending scan so the lowest starved index is the last writer.
        for (int i = 6; i >= 0; i--) begin
            if (eligible[i] && starved_q[i]) begin
                win       = 3'(i);
                win_found = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arb_go) state_d = GRANT;
            end
            GRANT, HOLD: begin
                if (iStall)      state_d = HOLD;
                else if (arb_go) state_d = GRANT;
                else             state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        if (state_d == GRANT) begin
            grant_d = 7'd1 << win;
            sel_d   = win + 3'd1;
            valid_d = 1'b1;
            ptr_d   = (win == 3'd6) ? 3'd0 : win + 3'd1;
        end else if (state_d == IDLE) begin
            grant_d = 7'd0;
            sel_d   = 3'd0;
            valid_d = 1'b0;
        end
    end

`ifdef COMMIT_BUS_SCHEDULER_AGING_EN
    logic [3:0] age_q [7];
    logic [3:0] age_d [7];

    always_comb begin
        for (int i = 0; i < 7; i++) begin
            age_d[i] = age_q[i];
            if (!iRequest[i] || (state_d == GRANT && win == 3'(i)))
                age_d[i] = 4'd0;
            else if (state_q != HOLD && age_q[i] < 4'(AGE_LIMIT))
                age_d[i] = age_q[i] + 4'd1;
            starved_d[i] = (age_d[i] == 4'(AGE_LIMIT));
        end
    end

    always_ff @(posedge Clock) begin
        for (int i = 0; i < 7; i++) begin
            if (Reset) age_q[i] <= 4'd0;
            else       age_q[i] <= age_d[i];
        end
    end
`else
    assign starved_d = 7'd0;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            grant_q   <= 7'd0;
            sel_q     <= 3'd0;
            valid_q   <= 1'b0;
            ptr_q     <= 3'd0;
            starved_q <= 7'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            sel_q     <= sel_d;
            valid_q   <= valid_d;
            ptr_q     <= ptr_d;
            starved_q <= starved_d;
        end
    end

    assign oGrant       = grant_q;
    assign oGrantValid  = valid_q;
    assign oBusSelector = sel_q;
    assign oStarved     = starved_q;

endmodule

// File: tb/tb_commit_bus_scheduler.sv
// Scoreboard bench for commit_bus_scheduler (default build, no aging).
// Stimulus pushes expected grants; a monitor pops and checks each cycle.
module tb_commit_bus_scheduler;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       iEnable;
    logic       iStall;
    logic [6:0] iRequest;
    logic [6:0] oGrant;
    logic       oGrantValid;
    logic [2:0] oBusSelector;
    logic [6:0] oStarved;

    typedef struct {
        logic [6:0] g;
        string      nm;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    commit_bus_scheduler #(.AGE_LIMIT(12)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .iEnable     (iEnable),
        .iStall      (iStall),
        .iRequest    (iRequest),
        .oGrant      (oGrant),
        .oGrantValid (oGrantValid),
        .oBusSelector(oBusSelector),
        .oStarved    (oStarved)
    );

    always #5 Clock = ~Clock;

    function automatic logic [2:0] enc(input logic [6:0] g);
        for (int i = 0; i < 7; i++)
            if (g[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    task automatic chk(input string nm, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, f, act, exp);
        end
    endtask

    task automatic step(input string nm, input bit r, input bit e,
                        input bit s, input logic [6:0] req,
                        input logic [6:0] g);
        exp_t x;
        Reset    = r;
        iEnable  = e;
        iStall   = s;
        iRequest = req;
        x.g  = g;
        x.nm = nm;
        q.push_back(x);
        @(posedge Clock);
        #1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge Clock);
            #2;
            if (q.size() > 0) begin
                x = q.pop_front();
                chk(x.nm, "grant", 32'(oGrant), 32'(x.g));
                chk(x.nm, "sel", 32'(oBusSelector), 32'(enc(x.g)));
                chk(x.nm, "valid", 32'(oGrantValid), 32'(x.g != 7'd0));
                chk(x.nm, "starved", 32'(oStarved), 32'd0);
            end
        end
    end

    initial begin : stim
        Reset    = 1'b1;
        iEnable  = 1'b0;
        iStall   = 1'b0;
        iRequest = 7'd0;

        step("reset", 1, 1, 1, 7'h7f, 7'b0000000);
        // single requester: granted, masked, granted again (P -> 3)
        step("s2_a", 0, 1, 0, 7'b0000100, 7'b0000100);
        step("s2_mask", 0, 1, 0, 7'b0000100, 7'b0000000);
        step("s2_b", 0, 1, 0, 7'b0000100, 7'b0000100);
        step("s2_drop", 0, 1, 0, 7'b0000000, 7'b0000000);
        // disabled arbiter stays idle
        step("dis_a", 0, 0, 0, 7'b0000011, 7'b0000000);
        step("dis_b", 0, 0, 0, 7'b0000011, 7'b0000000);

        // full round-robin sweep with wrap
        step("rst2", 1, 0, 0, 7'b0000000, 7'b0000000);
        for (int i = 0; i < 8; i++)
            step($sformatf("rr%0d", i), 0, 1, 0, 7'h7f,
                 7'd1 << (i % 7));

        // stall holds station 3 for five cycles, then P = 4
        step("rst3", 1, 0, 0, 7'b0000000, 7'b0000000);
        step("s3", 0, 1, 0, 7'b0001000, 7'b0001000);
        for (int i = 0; i < 4; i++)
            step($sformatf("hold%0d", i), 0, 1, 1, 7'b1011001,
                 7'b0001000);
        step("post_hold", 0, 1, 0, 7'b1010001, 7'b0010000);
        step("next6", 0, 1, 0, 7'b1010001, 7'b1000000);
        step("wrap0", 0, 1, 0, 7'b1010001, 7'b0000001);
        step("en_off", 0, 0, 0, 7'b1010001, 7'b0000000);

        // reset during hold abandons grant
        step("rst4", 1, 0, 0, 7'b0000000, 7'b0000000);
        step("s5", 0, 1, 0, 7'b0100000, 7'b0100000);
        step("s5_hold", 0, 1, 1, 7'b0100000, 7'b0100000);
        step("rst_hold", 1, 1, 1, 7'b0100000, 7'b0000000);
        step("after_rst", 0, 1, 0, 7'b0000001, 7'b0000001);
        // stall while idle issues nothing
        step("idle_drop", 0, 1, 0, 7'b0000000, 7'b0000000);
        step("idle_stall", 0, 1, 1, 7'b0000010, 7'b0000000);
        step("idle_go", 0, 1, 0, 7'b0000010, 7'b0000010);
        step("idle_end", 0, 1, 0, 7'b0000000, 7'b0000000);

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(posedge Clock);
        #5;
        if (q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
